idli_sqi_mem: RTL and testbench



---
 rtl/idli_sqi_mem.sv | 156 +++++++++++++++
 tb/tb_idli_sqi_mem.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem.sv
// idli_sqi_mem: SQI (quad-SPI) serial SRAM model, 23LC1024-style sequential mode.
// One instance holds one byte lane; sck is oversampled on the gck domain.
`default_nettype none

module idli_sqi_mem #(
   parameter int DEPTH = 65536
) (
   input  logic       i_sqi_gck,
   input  logic       i_sqi_rst_n,
   input  logic       i_sqi_sck,
   input  logic       i_sqi_cs,
   input  logic [3:0] i_sqi_sio,
   output logic [3:0] o_sqi_sio
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] ST_CMD    = 3'd0;
   localparam logic [2:0] ST_ADDR   = 3'd1;
   localparam logic [2:0] ST_DUMMY  = 3'd2;
   localparam logic [2:0] ST_RDATA  = 3'd3;
   localparam logic [2:0] ST_WDATA  = 3'd4;
   localparam logic [2:0] ST_IGNORE = 3'd5;

   logic [7:0]    data_q [0:DEPTH-1];

   logic          sck_q;
   logic          rise;
   logic          fall;
   logic [2:0]    state;
   logic [2:0]    cnt;
   logic [19:0]   shift;
   logic          is_write;
   logic          half;
   logic [3:0]    hi;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_inc;
   logic [AW-1:0] addr_load;
   logic [7:0]    cmd;
   logic [7:0]    rd_byte;
   logic          wr_en;

   assign rise      = i_sqi_sck & ~sck_q;
   assign fall      = ~i_sqi_sck & sck_q;
   assign cmd       = {shift[3:0], i_sqi_sio};
   assign addr_load = AW'({shift, i_sqi_sio} % 24'(DEPTH));
   assign addr_inc  = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
   assign rd_byte   = data_q[addr];
   assign wr_en     = rise & ~i_sqi_cs & (state == ST_WDATA) & half;

   // Array has no reset so preloaded contents survive a reset pulse.
   always_ff @(posedge i_sqi_gck) begin
      if (wr_en) begin
         data_q[addr] <= {hi, i_sqi_sio};
      end
   end

   always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
      if (!i_sqi_rst_n) begin
         sck_q     <= 1'b0;
         state     <= ST_CMD;
         cnt       <= 3'd0;
         shift     <= 20'd0;
         is_write  <= 1'b0;
         half      <= 1'b0;
         hi        <= 4'h0;
         addr      <= '0;
         o_sqi_sio <= 4'h0;
      end else begin
         sck_q <= i_sqi_sck;
         if (i_sqi_cs) begin
            state     <= ST_CMD;
            cnt       <= 3'd0;
            half      <= 1'b0;
            o_sqi_sio <= 4'h0;
         end else begin
            case (state)
               ST_CMD: begin
                  if (rise) begin
                     shift <= {shift[15:0], i_sqi_sio};
                     if (cnt == 3'd1) begin
                        cnt <= 3'd0;
                        case (cmd)
                           8'h03: begin
                              state    <= ST_ADDR;
                              is_write <= 1'b0;
                           end
                           8'h02: begin
                              state    <= ST_ADDR;
                              is_write <= 1'b1;
                           end
                           default: state <= ST_IGNORE;
                        endcase
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
               end
               ST_ADDR: begin
                  if (rise) begin
                     shift <= {shift[15:0], i_sqi_sio};
                     if (cnt == 3'd5) begin
                        cnt   <= 3'd0;
                        addr  <= addr_load;
                        half  <= 1'b0;
                        state <= is_write ? ST_WDATA : ST_DUMMY;
                     end else begin
                        cnt <= cnt + 3'd1;
                     end
                  end
               end
               ST_DUMMY: begin
                  if (rise && cnt != 3'd2) begin
                     cnt <= cnt + 3'd1;
                  end
                  if (fall && cnt == 3'd2) begin
                     o_sqi_sio <= rd_byte[7:4];
                     half      <= 1'b1;
                     state     <= ST_RDATA;
                  end
               end
               ST_RDATA: begin
                  // half=1 means the high nibble of the current byte is on the bus.
                  if (fall) begin
                     if (half) begin
                        o_sqi_sio <= rd_byte[3:0];
                        addr      <= addr_inc;
                        half      <= 1'b0;
                     end else begin
                        o_sqi_sio <= rd_byte[7:4];
                        half      <= 1'b1;
                     end
                  end
               end
               ST_WDATA: begin
                  if (rise) begin
                     if (half) begin
                        addr <= addr_inc;
                        half <= 1'b0;
                     end else begin
                        hi   <= i_sqi_sio;
                        half <= 1'b1;
                     end
                  end
               end
               default: begin
                  o_sqi_sio <= 4'h0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_mem.sv
// tb_idli_sqi_mem: scoreboard bench for the SQI SRAM model against a byte-array reference.
`default_nettype none

module tb_idli_sqi_mem;

   localparam int DEPTH = 65536;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck = 1'b0;
   logic       cs = 1'b1;
   logic [3:0] sio_in = 4'h0;
   logic [3:0] sio_out;

   logic [7:0] model [0:DEPTH-1];
   logic [3:0] sb [$];
   logic [7:0] wq [$];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   idli_sqi_mem #(.DEPTH(DEPTH)) dut (
      .i_sqi_gck   (clk),
      .i_sqi_rst_n (rst_n),
      .i_sqi_sck   (sck),
      .i_sqi_cs    (cs),
      .i_sqi_sio   (sio_in),
      .o_sqi_sio   (sio_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Nibble k of a sequential read stream starting at byte address a.
   function automatic logic [3:0] nib(input int a, input int k);
      logic [7:0] b;
      b = model[(a + k / 2) % DEPTH];
      return (k % 2 == 0) ? b[7:4] : b[3:0];
   endfunction

   task automatic poke(input int a, input logic [7:0] b);
      model[a] = b;
      dut.data_q[a] = b;
   endtask

   task automatic beat(input logic [3:0] n, input logic [3:0] exp);
      sb.push_back(exp);
      sio_in = n;
      sck = 1'b1;
      repeat (3) @(negedge clk);
      sck = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic sel();
      cs = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic desel();
      cs = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] c, input logic [23:0] a24);
      beat(c[7:4], 4'h0);
      beat(c[3:0], 4'h0);
      for (int i = 5; i >= 0; i--) beat(a24[i*4 +: 4], 4'h0);
   endtask

   task automatic do_read(input logic [23:0] a24, input int nd);
      int a;
      a = int'(a24) % DEPTH;
      sel();
      send_hdr(8'h03, a24);
      beat(4'($urandom), 4'h0);
      beat(4'($urandom), nib(a, 0));
      for (int k = 1; k <= nd; k++) beat(4'($urandom), nib(a, k));
      desel();
   endtask

   // Writes every byte queued in wq; optional trailing half byte must be dropped.
   task automatic do_write(input logic [23:0] a24, input bit partial);
      int a;
      logic [7:0] b;
      a = int'(a24) % DEPTH;
      sel();
      send_hdr(8'h02, a24);
      for (int i = 0; i < wq.size(); i++) begin
         b = wq[i];
         beat(b[7:4], 4'h0);
         beat(b[3:0], 4'h0);
         model[(a + i) % DEPTH] = b;
      end
      if (partial) beat(4'($urandom), 4'h0);
      desel();
      wq.delete();
   endtask

   task automatic do_other(input logic [7:0] c, input int nb);
      sel();
      beat(c[7:4], 4'h0);
      beat(c[3:0], 4'h0);
      for (int i = 0; i < nb; i++) beat(4'($urandom), 4'h0);
      desel();
   endtask

   task automatic mem_check(input string name);
      int errs;
      errs = 0;
      for (int i = 0; i < DEPTH; i++) if (dut.data_q[i] !== model[i]) errs++;
      check(name, errs, 0);
   endtask

   initial begin
      #1;
      forever begin
         @(negedge sck);
         repeat (2) @(posedge clk);
         @(negedge clk);
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sio_unexpected: got %0h want no fall pending", sio_out);
         end else begin
            check("sio", {28'd0, sio_out}, {28'd0, sb.pop_front()});
         end
      end
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: got still running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  b;
      logic [7:0]  c;
      logic [23:0] a24;
      int          n;

      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         poke(i, b);
      end
      repeat (3) @(negedge clk);
      check("reset_sio", {28'd0, sio_out}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      poke(16'h1234, 8'hA5);
      poke(16'h1235, 8'h3C);
      do_read(24'h00_12_34, 3);

      wq.push_back(8'hDE);
      wq.push_back(8'hAD);
      do_write(24'h00_00_10, 1'b0);
      check("write_de", {24'd0, dut.data_q[16]}, 32'hDE);
      check("write_ad", {24'd0, dut.data_q[17]}, 32'hAD);
      do_read(24'h00_00_10, 3);

      poke(16'hFFFF, 8'h11);
      poke(16'h0000, 8'h22);
      do_read(24'h00_FF_FF, 3);

      b = model[16'h0020];
      sel();
      send_hdr(8'h02, 24'h00_00_20);
      beat(4'h7, 4'h0);
      desel();
      check("abort_keep", {24'd0, dut.data_q[16'h0020]}, {24'd0, b});
      do_read(24'h00_00_20, 2);

      do_other(8'h9F, 8);
      mem_check("mem_after_directed");

      for (int t = 0; t < 24; t++) begin
         a24 = 24'($urandom);
         if ($urandom_range(0, 3) == 0) a24 = 24'(DEPTH - 1 - $urandom_range(0, 2));
         n = $urandom_range(1, 7);
         case ($urandom_range(0, 4))
            0, 1: do_read(a24, n);
            2, 3: begin
               for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
               do_write(a24, 1'($urandom));
            end
            default: begin
               c = 8'($urandom);
               if (c == 8'h02 || c == 8'h03) c = 8'h05;
               do_other(c, n);
            end
         endcase
      end
      mem_check("mem_after_random");

      poke(16'h4000, 8'h5A);
      poke(16'h4001, 8'hC3);
      sel();
      send_hdr(8'h03, 24'h00_40_00);
      beat(4'h0, 4'h0);
      beat(4'h0, 4'h5);
      beat(4'h0, 4'hA);
      beat(4'h0, 4'hC);
      rst_n = 1'b0;
      #1;
      check("reset_mid_read", {28'd0, sio_out}, 0);
      @(negedge clk);
      cs = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mem_check("mem_after_reset");
      do_read(24'h00_40_00, 3);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("sb_drain", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
